// File: rtl/video_timing_pkg.sv
// Shared mode constants and helpers for the raster timing generator.
package video_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned front;
    int unsigned sync;
    int unsigned back;
  } axis_mode_t;

  localparam axis_mode_t VGA640_H = '{active: 640, front: 16, sync: 96,  back: 48};
  localparam axis_mode_t VGA640_V = '{active: 480, front: 10, sync: 2,   back: 33};
  localparam axis_mode_t SVGA800_H = '{active: 800, front: 40, sync: 128, back: 88};
  localparam axis_mode_t SVGA800_V = '{active: 600, front: 1,  sync: 4,   back: 23};

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Timing bundle between the raster generator and its consumers (pixel fetch, sync delay line).
interface video_timing_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
) ();

  logic          EN;
  logic [XW-1:0] X;
  logic [YW-1:0] Y;
  logic          DE;
  logic          HSYNC;
  logic          VSYNC;
  logic          LINE;
  logic          FRAME;

  modport master (
    input  EN,
    output X, Y, DE, HSYNC, VSYNC, LINE, FRAME
  );

  modport slave (
    output EN,
    input  X, Y, DE, HSYNC, VSYNC, LINE, FRAME
  );

endinterface

// File: rtl/video_timing_axis.sv
// One raster axis: wrapping position counter with registered region flags
// decoded from the next count, so flags always match the current count.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = 4,
  parameter int unsigned FRONT_LEN  = 1,
  parameter int unsigned SYNC_LEN   = 2,
  parameter int unsigned BACK_LEN   = 1,
  parameter int unsigned CW         = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic          active,
  output logic          sync,
  output logic          wrap,
  output logic          zero
);

  localparam int unsigned TOTAL = axis_total(ACTIVE_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);

  if (ACTIVE_LEN < 1 || FRONT_LEN < 1 || SYNC_LEN < 1 || BACK_LEN < 1) begin : g_bad_len
    $error("video_timing_axis: every region width must be at least 1");
  end
  if ((64'd1 << CW) < 64'(TOTAL)) begin : g_bad_width
    $error("video_timing_axis: counter width too small for axis total");
  end

  localparam logic [CW-1:0] Last      = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ActEnd    = CW'(ACTIVE_LEN);
  localparam logic [CW-1:0] SyncStart = CW'(ACTIVE_LEN + FRONT_LEN);
  localparam logic [CW-1:0] SyncEnd   = CW'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

  logic [CW-1:0] count_q, count_d;
  logic          active_q, sync_q, wrap_q, zero_q;

  always_comb begin
    count_d = count_q;
    if (RST) begin
      count_d = '0;
    end else if (step) begin
      count_d = (count_q == Last) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    count_q  <= count_d;
    active_q <= (count_d < ActEnd);
    sync_q   <= (count_d >= SyncStart) && (count_d < SyncEnd);
    wrap_q   <= (count_d == Last);
    zero_q   <= (count_d == '0);
  end

  assign count  = count_q;
  assign active = active_q;
  assign sync   = sync_q;
  assign wrap   = wrap_q;
  assign zero   = zero_q;

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: horizontal and vertical axes plus output decode.
// Define VIDEO_TIMING_SYNC_POS_EN for active-high HSYNC/VSYNC (default active-low).
module video_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA640_H.active,
  parameter int unsigned H_FRONT  = VGA640_H.front,
  parameter int unsigned H_SYNC   = VGA640_H.sync,
  parameter int unsigned H_BACK   = VGA640_H.back,
  parameter int unsigned V_ACTIVE = VGA640_V.active,
  parameter int unsigned V_FRONT  = VGA640_V.front,
  parameter int unsigned V_SYNC   = VGA640_V.sync,
  parameter int unsigned V_BACK   = VGA640_V.back,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10
) (
  input  logic            CLK,
  input  logic            RST,
  video_timing_if.master  vt
);

  logic [XW-1:0] h_count;
  logic [YW-1:0] v_count;
  logic          h_active, h_sync, h_wrap, h_zero;
  logic          v_active, v_sync, v_zero;
  logic          unused_v_wrap;

  video_timing_axis #(
    .ACTIVE_LEN (H_ACTIVE),
    .FRONT_LEN  (H_FRONT),
    .SYNC_LEN   (H_SYNC),
    .BACK_LEN   (H_BACK),
    .CW         (XW)
  ) u_h_axis (
    .CLK    (CLK),
    .RST    (RST),
    .step   (vt.EN),
    .count  (h_count),
    .active (h_active),
    .sync   (h_sync),
    .wrap   (h_wrap),
    .zero   (h_zero)
  );

  // h_wrap is a level at h==H_TOTAL-1, so the line only advances on an enabled wrap.
  video_timing_axis #(
    .ACTIVE_LEN (V_ACTIVE),
    .FRONT_LEN  (V_FRONT),
    .SYNC_LEN   (V_SYNC),
    .BACK_LEN   (V_BACK),
    .CW         (YW)
  ) u_v_axis (
    .CLK    (CLK),
    .RST    (RST),
    .step   (vt.EN & h_wrap),
    .count  (v_count),
    .active (v_active),
    .sync   (v_sync),
    .wrap   (unused_v_wrap),
    .zero   (v_zero)
  );

  assign vt.X     = h_count;
  assign vt.Y     = v_count;
  assign vt.DE    = h_active & v_active;
  assign vt.LINE  = h_zero;
  assign vt.FRAME = h_zero & v_zero;

`ifdef VIDEO_TIMING_SYNC_POS_EN
  assign vt.HSYNC = h_sync;
  assign vt.VSYNC = v_sync;
`else
  assign vt.HSYNC = ~h_sync;
  assign vt.VSYNC = ~v_sync;
`endif

endmodule
